// File: rtl/onehot_checker.sv
// rtl/onehot_checker.sv - registered multi-channel one-hot checker, encoder and violation monitor
module onehot_checker #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8,
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           valid,
  input  logic [CHANNELS*WIDTH-1:0]     vec,
  input  logic [CHANNELS-1:0]           allow_zero,
  input  logic                          clear,
  output logic [CHANNELS-1:0]           is_onehot,
  output logic [CHANNELS*IDX_W-1:0]     idx,
  output logic [CHANNELS-1:0]           err_now,
  output logic [CHANNELS-1:0]           err_sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0] err_cnt,
  output logic                          first_err_valid,
  output logic [CHAN_W-1:0]             first_err_chan,
  output logic [WIDTH-1:0]              first_err_vec
);

  // Capture flag is a two-state machine: EMPTY until a violation is seen, HELD until clear/rst.
  localparam logic CAP_EMPTY = 1'b0;
  localparam logic CAP_HELD  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                          cap_state;
  logic                          cap_state_next;
  logic [CHAN_W-1:0]             cap_chan_next;
  logic [WIDTH-1:0]              cap_vec_next;

  logic [CHANNELS-1:0]           hit;
  logic [CHANNELS-1:0]           viol;
  logic [CHANNELS*IDX_W-1:0]     idx_next;
  logic [CHANNELS-1:0]           sticky_next;
  logic [CHANNELS*CNT_WIDTH-1:0] cnt_next;

  logic [WIDTH-1:0]              v;
  logic [WIDTH-1:0]              v_lowcut;
  logic                          v_zero;
  logic                          v_onehot;
  logic [IDX_W-1:0]              enc;
  logic [CNT_WIDTH-1:0]          cnt_base;
  logic [CHAN_W-1:0]             win_chan;
  logic [WIDTH-1:0]              win_vec;

  // Per-channel classification, index encoding and next sticky/counter values.
  always_comb begin
    hit         = '0;
    viol        = '0;
    idx_next    = idx;
    sticky_next = '0;
    cnt_next    = '0;
    v           = '0;
    v_lowcut    = '0;
    v_zero      = 1'b0;
    v_onehot    = 1'b0;
    enc         = '0;
    cnt_base    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      v        = vec[c*WIDTH +: WIDTH];
      v_lowcut = v & (v - WIDTH'(1));
      v_zero   = ~|v;
      v_onehot = (|v) & (v_lowcut == '0);
      // OR-encoding is exact only for one-hot inputs; the result is used only then.
      enc = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) enc = enc | IDX_W'(i);
      end
      hit[c]  = valid[c] & v_onehot;
      viol[c] = valid[c] & ~v_onehot & ~(v_zero & allow_zero[c]);
      if (hit[c]) idx_next[c*IDX_W +: IDX_W] = enc;
      // A clear in the same cycle as a violation wipes history first, then records it.
      sticky_next[c] = (clear ? 1'b0 : err_sticky[c]) | viol[c];
      cnt_base       = clear ? '0 : err_cnt[c*CNT_WIDTH +: CNT_WIDTH];
      if (viol[c] && cnt_base != CNT_MAX)
        cnt_next[c*CNT_WIDTH +: CNT_WIDTH] = cnt_base + CNT_WIDTH'(1);
      else
        cnt_next[c*CNT_WIDTH +: CNT_WIDTH] = cnt_base;
    end
  end

  // Lowest-numbered violating channel wins the first-error capture.
  always_comb begin
    win_chan = '0;
    win_vec  = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (viol[c]) begin
        win_chan = CHAN_W'(c);
        win_vec  = vec[c*WIDTH +: WIDTH];
      end
    end
  end

  // Capture next-state: clear empties it, then an empty capture loads on any violation.
  always_comb begin
    cap_state_next = clear ? CAP_EMPTY : cap_state;
    cap_chan_next  = clear ? '0 : first_err_chan;
    cap_vec_next   = clear ? '0 : first_err_vec;
    if (cap_state_next == CAP_EMPTY && |viol) begin
      cap_state_next = CAP_HELD;
      cap_chan_next  = win_chan;
      cap_vec_next   = win_vec;
    end
  end

  // Register all results; reset overrides clear and sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_onehot      <= '0;
      idx            <= '0;
      err_now        <= '0;
      err_sticky     <= '0;
      err_cnt        <= '0;
      cap_state      <= CAP_EMPTY;
      first_err_chan <= '0;
      first_err_vec  <= '0;
    end else begin
      is_onehot      <= hit;
      idx            <= idx_next;
      err_now        <= viol;
      err_sticky     <= sticky_next;
      err_cnt        <= cnt_next;
      cap_state      <= cap_state_next;
      first_err_chan <= cap_chan_next;
      first_err_vec  <= cap_vec_next;
    end
  end

  assign first_err_valid = cap_state;

endmodule

// File: tb/tb_onehot_checker.sv
// tb/tb_onehot_checker.sv - scoreboard bench for onehot_checker with directed vectors
module tb_onehot_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] valid = '0;
  logic [7:0] vec = '0;
  logic [1:0] allow_zero = '0;
  logic       clear = 1'b0;
  logic [1:0] is_onehot;
  logic [3:0] idx;
  logic [1:0] err_now;
  logic [1:0] err_sticky;
  logic [3:0] err_cnt;
  logic       first_err_valid;
  logic [0:0] first_err_chan;
  logic [3:0] first_err_vec;

  onehot_checker #(.WIDTH(4), .CHANNELS(2), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .vec(vec), .allow_zero(allow_zero),
    .clear(clear), .is_onehot(is_onehot), .idx(idx), .err_now(err_now),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .first_err_valid(first_err_valid),
    .first_err_chan(first_err_chan), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    int         step;
    logic [1:0] oh;
    logic [3:0] ix;
    logic [1:0] now;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       fev;
    logic       fec;
    logic [3:0] fevec;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, step, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents registered results; compare against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].tgt < cyc) begin
      chk("missed_sample", exp_q[0].step, 32'(cyc), 32'(exp_q[0].tgt));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("is_onehot",       e.step, 32'(is_onehot),       32'(e.oh));
      chk("idx",             e.step, 32'(idx),             32'(e.ix));
      chk("err_now",         e.step, 32'(err_now),         32'(e.now));
      chk("err_sticky",      e.step, 32'(err_sticky),      32'(e.st));
      chk("err_cnt",         e.step, 32'(err_cnt),         32'(e.cnt));
      chk("first_err_valid", e.step, 32'(first_err_valid), 32'(e.fev));
      chk("first_err_chan",  e.step, 32'(first_err_chan),  32'(e.fec));
      chk("first_err_vec",   e.step, 32'(first_err_vec),   32'(e.fevec));
    end
  end

  // Drive one cycle of inputs and push the hand-computed response for the following edge.
  task automatic drive(input logic r, input logic cl, input logic [1:0] vl, input logic [7:0] vv,
                       input logic [1:0] az, input logic [1:0] oh, input logic [3:0] ix,
                       input logic [1:0] now, input logic [1:0] st, input logic [3:0] cnt,
                       input logic fev, input logic fec, input logic [3:0] fevec);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; clear = cl; valid = vl; vec = vv; allow_zero = az;
    e.tgt = cyc + 1; e.step = step_no; e.oh = oh; e.ix = ix; e.now = now; e.st = st;
    e.cnt = cnt; e.fev = fev; e.fec = fec; e.fevec = fevec;
    exp_q.push_back(e);
    step_no++;
  endtask

  initial begin
    //     rst  clr  valid  vec{ch1,ch0}     az     oh     idx      now    st     cnt      fev  fec  fevec
    drive(1'b1,1'b0,2'b00,{4'b0000,4'b0000},2'b00,2'b00,4'b0000,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b0100},2'b00,2'b01,4'b0010,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b10,{4'b0110,4'b0000},2'b00,2'b00,4'b0010,2'b10,2'b10,4'b0100,1'b1,1'b1,4'b0110);
    drive(1'b0,1'b0,2'b00,{4'b1111,4'b1111},2'b00,2'b00,4'b0010,2'b00,2'b10,4'b0100,1'b1,1'b1,4'b0110);
    drive(1'b0,1'b0,2'b11,{4'b0000,4'b0000},2'b01,2'b00,4'b0010,2'b10,2'b10,4'b1000,1'b1,1'b1,4'b0110);
    drive(1'b0,1'b1,2'b00,{4'b0000,4'b0000},2'b00,2'b00,4'b0010,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b11,{4'b1010,4'b0011},2'b00,2'b00,4'b0010,2'b11,2'b11,4'b0101,1'b1,1'b0,4'b0011);
    drive(1'b0,1'b0,2'b10,{4'b1100,4'b0001},2'b00,2'b00,4'b0010,2'b10,2'b11,4'b1001,1'b1,1'b0,4'b0011);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b1000},2'b00,2'b01,4'b0011,2'b00,2'b11,4'b1001,1'b1,1'b0,4'b0011);
    drive(1'b0,1'b0,2'b10,{4'b0010,4'b0000},2'b00,2'b10,4'b0111,2'b00,2'b11,4'b1001,1'b1,1'b0,4'b0011);
    drive(1'b0,1'b1,2'b01,{4'b0000,4'b0101},2'b00,2'b00,4'b0111,2'b01,2'b01,4'b0001,1'b1,1'b0,4'b0101);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b1111},2'b00,2'b00,4'b0111,2'b01,2'b01,4'b0010,1'b1,1'b0,4'b0101);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b1111},2'b00,2'b00,4'b0111,2'b01,2'b01,4'b0011,1'b1,1'b0,4'b0101);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b1111},2'b00,2'b00,4'b0111,2'b01,2'b01,4'b0011,1'b1,1'b0,4'b0101);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b1111},2'b00,2'b00,4'b0111,2'b01,2'b01,4'b0011,1'b1,1'b0,4'b0101);
    drive(1'b1,1'b0,2'b11,{4'b1111,4'b1111},2'b00,2'b00,4'b0000,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b00,{4'b1111,4'b1111},2'b00,2'b00,4'b0000,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b0000},2'b01,2'b00,4'b0000,2'b00,2'b00,4'b0000,1'b0,1'b0,4'b0000);
    drive(1'b0,1'b0,2'b01,{4'b0000,4'b0000},2'b00,2'b00,4'b0000,2'b01,2'b01,4'b0001,1'b1,1'b0,4'b0000);
    @(posedge clk);
    #2;
    valid = 2'b00; clear = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_checker.md
Name: onehot_checker

Overview:
- Registered, multi-channel one-hot checker and encoder for crossbar grant/select vectors.
- Each cycle, every channel's qualified vector is classified as one-hot, all-zero or multi-hot. Illegal vectors are flagged, counted and captured for debug.
- Legal one-hot vectors are encoded to a binary index.
- Sits after arbiters and before mux-select logic, as both a datapath encoder and an assertion-grade monitor.

Parameters:
- WIDTH, 4, bits per channel vector (>=1).
- CHANNELS, 2, number of independent vectors checked in parallel (>=1).
- CNT_WIDTH, 8, width of each per-channel saturating error counter (>=1).
- IDX_W, derived: max(1, $clog2(WIDTH)). Not user-overridable.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- valid  input  CHANNELS  per-channel qualifier; bit c enables checking of channel c
- vec  input  CHANNELS*WIDTH  packed vectors, channel c at [c*WIDTH +: WIDTH]
- allow_zero  input  CHANNELS  per-channel mode: 1 = all-zero legal (onehot0), 0 = exactly one bit required
- clear  input  1  synchronous clear of sticky flags, counters and first-error capture
- is_onehot  output  CHANNELS  registered: channel had valid and exactly one bit set last cycle
- idx  output  CHANNELS*IDX_W  registered binary index of the set bit, channel c at [c*IDX_W +: IDX_W]
- err_now  output  CHANNELS  registered single-cycle violation pulse
- err_sticky  output  CHANNELS  sticky violation flag
- err_cnt  output  CHANNELS*CNT_WIDTH  saturating violation counters, packed as for idx
- first_err_valid  output  1  first-error capture holds data
- first_err_chan  output  max(1,$clog2(CHANNELS))  channel of first captured violation
- first_err_vec  output  WIDTH  vector of first captured violation

Behaviour:
- Reset (rst=1 at clock edge): every output and all state go to 0. rst has priority over clear and all sampling.
- Classification per channel c, combinational on the inputs:
  - zero = ~|v.
  - onehot = (|v) & ((v & (v-1)) == 0), or an equivalent prefix-mask method.
  - violation = valid[c] & ~onehot & ~(zero & allow_zero[c]).
- Latency is exactly 1 cycle. Inputs are sampled at edge N; the results appear after edge N and hold for one cycle.
- is_onehot[c] = valid[c] & onehot. It is 0 when valid[c]=0.
- idx for channel c:
  - Updates only when is_onehot is set; otherwise it holds its previous value.
  - Encoding is the position of the set bit.
  - For WIDTH=1, idx is always 0.
- err_now[c] = violation, registered. It is 0 whenever valid[c]=0, whatever vec contains.
- err_sticky[c] is set on violation and stays set until clear or rst.
- err_cnt[c] increments by 1 per violation cycle and saturates at 2^CNT_WIDTH-1 with no wrap.
- First-error capture:
  - Loads when first_err_valid=0 and any channel violates.
  - If several channels violate in the same cycle, the lowest channel index wins.
  - Once first_err_valid=1, later violations never overwrite the capture.
- clear:
  - Zeroes err_sticky, err_cnt and the first-error capture.
  - If a violation occurs in the same cycle as clear, it is recorded after clearing: sticky=1, cnt=1, capture loaded.
  - clear does not affect err_now, is_onehot or idx.
- Simultaneous events:
  - Channels are fully independent, except for first-error arbitration.
  - allow_zero changes take effect in the same sampling cycle.
- Reset mid-operation: pending results are discarded, and the first cycle after reset reports no activity.
- The block has no state machine beyond the capture flag. The capture is effectively a 2-state FSM, EMPTY -> HELD on violation, and HELD -> EMPTY on clear or rst.

Test Plan:
- Reset, then WIDTH=4, CHANNELS=2, valid=2'b01, vec ch0=4'b0100 -> next cycle: is_onehot=2'b01, idx ch0=2, err_now=0, counters 0.
- ch1 vec=4'b0110, valid[1]=1 -> err_now[1] pulses for 1 cycle, err_sticky[1]=1, err_cnt ch1=1, first_err_chan=1, first_err_vec=4'b0110.
- ch0 vec=0, allow_zero=2'b01, valid=2'b11, ch1 vec=0 -> ch0 no error; ch1 errors; is_onehot=0 for both; idx unchanged.
- Both channels multi-hot in the same cycle with capture empty -> first_err_chan=0. A later violation on ch1 alone leaves the capture unchanged.
- CNT_WIDTH=2, 5 consecutive violations on ch0 -> err_cnt ch0 reads 1, 2, 3, 3, 3.
- clear asserted with a simultaneous ch0 violation, and separately rst asserted mid-burst -> first case: cnt=1, sticky=1, capture=ch0. Second case: all outputs 0 on the following cycle.
- valid=0 with vec=4'b1111 -> no err_now, no count change.
